y86_imem_encoder: RTL and testbench

Writer end of the instruction-memory interface that the fetch stage reads. Accepts one Y86-64 instruction as decoded fields (icode, ifun, rA, rB, valC) and serialises it into the byte-wide instruction memory at a running write pointer, one byte per cycle, in the exact byte layout fetch decodes. Used by program loaders and benches to build imem images; its output stream must round-trip through fetch to identical fields and valP.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_instr_len.sv | 19 +
 rtl/y86_imem_encoder.sv | 145 ++++++++++++++
 tb/tb_y86_imem_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, register "none" code, encoder states and
// the icode -> {valid, length} table used by both encoder and fetch.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } enc_state_t;

    // Returns {valid, len}; len is 0 for icodes above POPQ.
    function automatic logic [4:0] y86_len_valid(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                  return {1'b1, 4'd1};
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:      return {1'b1, 4'd2};
            I_JXX, I_CALL:                         return {1'b1, 4'd9};
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:          return {1'b1, 4'd10};
            default:                               return {1'b0, 4'd0};
        endcase
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode classifier: byte length, validity and which optional
// fields (register byte, 8-byte constant) the encoding carries.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       valid,
    output logic       has_regs,
    output logic       has_valC
);

    always_comb begin
        {valid, len} = y86_len_valid(icode);
        has_regs     = valid && ((len == 4'd2) || (len == 4'd10));
        has_valC     = valid && (len >= 4'd9);
    end

endmodule

// File: rtl/y86_imem_encoder.sv
// Serialises one Y86-64 instruction into byte-wide imem at a running pointer.
// Optional Y86_ENC_REG_NORMALIZE_EN forces unused register nibbles / ifun.
//
// state  | meaning
// IDLE   | waiting for set_ptr or an instruction handshake
// EMIT   | writing one byte per cycle from the latched image
// DONE   | one-cycle done (and err when rejected) pulse
module y86_imem_encoder
    import y86_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_ptr,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic              err,
    output logic [3:0]        instr_len,
    output logic [ADDR_W-1:0] wr_ptr
);

    enc_state_t        state;
    logic [ADDR_W:0]   ptr_q;
    logic [71:0]       shreg;
    logic [3:0]        len_q;
    logic [3:0]        idx;

    logic [3:0]        len_c;
    logic              valid_c;
    logic              regs_c;
    logic              valc_c;
    logic [3:0]        ifun_n;
    logic [3:0]        ra_n;
    logic [3:0]        rb_n;
    logic [79:0]       img;
    logic [ADDR_W:0]   end_addr;
    logic              fits;

    y86_instr_len u_len (
        .icode   (icode),
        .len     (len_c),
        .valid   (valid_c),
        .has_regs(regs_c),
        .has_valC(valc_c)
    );

`ifdef Y86_ENC_REG_NORMALIZE_EN
    always_comb begin
        ra_n   = (icode == I_IRMOVQ) ? RNONE : rA;
        rb_n   = ((icode == I_PUSHQ) || (icode == I_POPQ)) ? RNONE : rB;
        ifun_n = ((icode == I_RRMOVQ) || (icode == I_OPQ) || (icode == I_JXX)) ? ifun : 4'h0;
    end
`else
    assign ra_n   = rA;
    assign rb_n   = rB;
    assign ifun_n = ifun;
`endif

    // Whole instruction image, byte 0 in bits [7:0], valC little-endian.
    always_comb begin
        img = {72'h0, icode, ifun_n};
        if (regs_c && valc_c)
            img = {valC, ra_n, rb_n, icode, ifun_n};
        else if (regs_c)
            img = {64'h0, ra_n, rb_n, icode, ifun_n};
        else if (valc_c)
            img = {8'h00, valC, icode, ifun_n};
    end

    // Pointer is kept one bit wider so an exact fill reads as full, not as 0.
    assign end_addr = ptr_q + (ADDR_W+1)'(len_c);
    assign fits     = (end_addr <= (ADDR_W+1)'(DEPTH));
    assign in_ready = (state == S_IDLE) && !set_ptr;
    assign wr_ptr   = ptr_q[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr_q     <= '0;
            shreg     <= '0;
            len_q     <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            instr_len <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (set_ptr) begin
                        ptr_q <= {1'b0, start_addr};
                    end else if (in_valid) begin
                        if (valid_c && fits) begin
                            state     <= S_EMIT;
                            mem_we    <= 1'b1;
                            mem_addr  <= ptr_q[ADDR_W-1:0];
                            mem_wdata <= img[7:0];
                            shreg     <= img[79:8];
                            len_q     <= len_c;
                            idx       <= 4'd1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (idx == len_q) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        ptr_q     <= ptr_q + (ADDR_W+1)'(len_q);
                        instr_len <= len_q;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= shreg[7:0];
                        shreg     <= {8'h00, shreg[71:8]};
                        idx       <= idx + 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Directed bench for y86_imem_encoder: vector table plus reset/set_ptr sequences.
module tb_y86_imem_encoder;

    logic        clk = 1'b0;
    logic        reset, set_ptr, in_valid;
    logic [9:0]  start_addr;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC;
    logic        in_ready, mem_we, done, err;
    logic [9:0]  mem_addr, wr_ptr;
    logic [7:0]  mem_wdata;
    logic [3:0]  instr_len;

    y86_imem_encoder #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk(clk), .reset(reset), .set_ptr(set_ptr), .start_addr(start_addr),
        .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .done(done), .err(err), .instr_len(instr_len),
        .wr_ptr(wr_ptr)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int n_wr   = 0;
    int exp_wr = 0;
    logic [7:0] mem [1024];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
    end

    typedef struct {
        logic        set;
        logic [9:0]  sp;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc;
        int          len;
        logic        rej;
        logic [9:0]  ptr_after;
        logic [3:0]  il_after;
    } vec_t;

    localparam int NV = 14;
    vec_t       vec [NV];
    logic [7:0] eb  [NV][10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_pointer(input logic [9:0] a);
        @(negedge clk);
        set_ptr = 1'b1;
        start_addr = a;
        @(negedge clk);
        set_ptr = 1'b0;
    endtask

    function automatic int flen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    task automatic run_vec(input int i);
        int guard;
        logic [9:0] base;
        if (vec[i].set) set_pointer(vec[i].sp);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d_ready", i), {63'h0, in_ready}, 64'h1);
        in_valid = 1'b1;
        icode = vec[i].ic; ifun = vec[i].fn; rA = vec[i].ra; rB = vec[i].rb; valC = vec[i].vc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
        valC = {$urandom, $urandom};
        if (vec[i].rej) begin
            @(negedge clk);
            chk($sformatf("v%0d_reject", i), {mem_we, done, err, wr_ptr, instr_len},
                {1'b0, 1'b1, 1'b1, vec[i].ptr_after, vec[i].il_after});
        end else begin
            base = vec[i].ptr_after - 10'(vec[i].len);
            for (int k = 0; k < vec[i].len; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_byte%0d", i, k), {done, mem_we, mem_addr, mem_wdata},
                    {1'b0, 1'b1, base + 10'(k), eb[i][k]});
            end
            exp_wr += vec[i].len;
            @(negedge clk);
            chk($sformatf("v%0d_done", i), {mem_we, done, err, wr_ptr, instr_len},
                {1'b0, 1'b1, 1'b0, vec[i].ptr_after, vec[i].il_after});
        end
        @(negedge clk);
        chk($sformatf("v%0d_idle", i), {62'h0, done, in_ready}, 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] dvalc;
        logic [3:0]  dic;
        int          valp;

        //          set   sp       ic    fn    ra    rb    valC                     len rej  ptr_after il_after
        vec[0]  = '{1'b1, 10'd0,   4'h3, 4'h0, 4'hF, 4'h3, 64'h123456789ABCDEF0,  10, 1'b0, 10'd10,  4'd10};
        vec[1]  = '{1'b1, 10'd32,  4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                  1, 1'b0, 10'd33,  4'd1};
        vec[2]  = '{1'b0, 10'd0,   4'h1, 4'h0, 4'h0, 4'h0, 64'h0,                  1, 1'b0, 10'd34,  4'd1};
        vec[3]  = '{1'b0, 10'd0,   4'h6, 4'h0, 4'h0, 4'h1, 64'h0,                  2, 1'b0, 10'd36,  4'd2};
        vec[4]  = '{1'b0, 10'd0,   4'h9, 4'h0, 4'h0, 4'h0, 64'h0,                  1, 1'b0, 10'd37,  4'd1};
        vec[5]  = '{1'b1, 10'd100, 4'h8, 4'h0, 4'hF, 4'hF, 64'h40,                 9, 1'b0, 10'd109, 4'd9};
        vec[6]  = '{1'b0, 10'd0,   4'hC, 4'h0, 4'h0, 4'h0, 64'h0,                  0, 1'b1, 10'd109, 4'd9};
        vec[7]  = '{1'b1, 10'd1016,4'h7, 4'h0, 4'hF, 4'hF, 64'h100,                0, 1'b1, 10'd1016,4'd9};
        vec[8]  = '{1'b1, 10'd1014,4'h4, 4'h0, 4'h1, 4'h2, 64'h0807060504030201,  10, 1'b0, 10'd0,   4'd10};
        vec[9]  = '{1'b0, 10'd0,   4'h1, 4'h0, 4'h0, 4'h0, 64'h0,                  0, 1'b1, 10'd0,   4'd10};
        vec[10] = '{1'b1, 10'd200, 4'hA, 4'h0, 4'h2, 4'h0, 64'h0,                  2, 1'b0, 10'd202, 4'd2};
        vec[11] = '{1'b0, 10'd0,   4'h0, 4'h5, 4'h0, 4'h0, 64'h0,                  1, 1'b0, 10'd203, 4'd1};
        vec[12] = '{1'b0, 10'd0,   4'h5, 4'h0, 4'h7, 4'h4, 64'hFFFFFFFFFFFFFFF8,  10, 1'b0, 10'd213, 4'd10};
        vec[13] = '{1'b0, 10'd0,   4'h7, 4'h3, 4'hF, 4'hF, 64'h1234,               9, 1'b0, 10'd222, 4'd9};

        eb[0]  = '{8'h30, 8'hF3, 8'hF0, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
        eb[1]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        eb[2]  = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        eb[3]  = '{8'h60, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        eb[4]  = '{8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        eb[5]  = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        eb[6]  = '{default: 8'h00};
        eb[7]  = '{default: 8'h00};
        eb[8]  = '{8'h40, 8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        eb[9]  = '{default: 8'h00};
`ifdef Y86_ENC_REG_NORMALIZE_EN
        eb[10] = '{8'hA0, 8'h2F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        eb[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        eb[10] = '{8'hA0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        eb[11] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        eb[12] = '{8'h50, 8'h74, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        eb[13] = '{8'h73, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        reset = 1'b1; set_ptr = 1'b0; in_valid = 1'b0; start_addr = '0;
        icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {mem_we, mem_addr, mem_wdata, done, err, instr_len, wr_ptr}, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", {63'h0, in_ready}, 64'h1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Round-trip of the call at 100 through a minimal fetch decode.
        dic = mem[100][7:4];
        for (int k = 0; k < 8; k++) dvalc[8*k +: 8] = mem[101 + k];
        valp = 100 + flen(dic);
        chk("fetch_icode", {60'h0, dic}, 64'h8);
        chk("fetch_valc", dvalc, 64'h40);
        chk("fetch_valp", 64'(valp), 64'd109);
        chk("exact_fit_last", {56'h0, mem[1023]}, 64'h08);

        // Reset during cycle 4 of a 10-byte write at pointer 222.
        @(negedge clk);
        in_valid = 1'b1; icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h1; valC = 64'h55;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst_pre_c%0d", c), {mem_we, mem_addr}, {1'b1, 10'd221 + 10'(c)});
        end
        reset = 1'b1;
        exp_wr += 4;
        @(negedge clk);
        chk("rst_abort", {mem_we, done, wr_ptr, instr_len}, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_release", {62'h0, mem_we, in_ready}, 64'h1);

        // set_ptr beats in_valid in the same cycle.
        set_ptr = 1'b1; start_addr = 10'd500;
        in_valid = 1'b1; icode = 4'h1; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = '0;
        #1 chk("setptr_blocks_ready", {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        chk("setptr_no_accept", {mem_we, wr_ptr}, {1'b0, 10'd500});
        set_ptr = 1'b0;
        #1 chk("setptr_ready_back", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("late_accept_byte", {mem_we, mem_addr, mem_wdata}, {1'b1, 10'd500, 8'h10});
        exp_wr += 1;
        set_ptr = 1'b1; start_addr = 10'd700;
        @(negedge clk);
        chk("late_accept_done", {done, err, wr_ptr}, {1'b1, 1'b0, 10'd501});
        @(negedge clk);
        chk("setptr_ignored_busy", {54'h0, wr_ptr}, 64'd501);
        set_ptr = 1'b0;
        @(negedge clk);
        chk("write_count", 64'(n_wr), 64'(exp_wr));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
